// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      StRun,
      StFlush,
      StMemWait,
      StDrain,
      StHalted
   } ctrl_state_t;

   localparam logic [3:0] HALT_OPCODE = 4'b1111;

   localparam int unsigned FLUSH_CNT_W = 3;
   localparam int unsigned WAIT_CNT_W  = 8;
   localparam int unsigned DRAIN_CNT_W = 8;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_out_t;

   localparam ctrl_out_t CTRL_GO     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_out_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_out_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam ctrl_out_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam ctrl_out_t CTRL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_out_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline controller: per-stage enables/flushes, branch flush, memory-wait freeze with
// timeout, halt drain and saturating stall/flush statistics.
module pipeline_control_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT  = 15,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use_hazard,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic [3:0]       opcode_decode,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT   = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST   = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   ctrl_state_t            state_q, state_d, ret_q, ret_d, eff_state;
   logic [FLUSH_CNT_W-1:0] flush_rem_q, flush_rem_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic                   timeout_q, timeout_d;
   logic                   released, mem_wait_req, stall_inc, flush_inc;
   ctrl_out_t              ctrl, ctrl_out;

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      flush_rem_d = flush_rem_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      timeout_d   = timeout_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      released    = 1'b0;
      eff_state   = state_q;
      ctrl        = CTRL_FREEZE;

      // A released wait behaves as its return state in the same cycle.
      if (state_q == StMemWait) begin
         if (mem_ready || (wait_cnt_q >= WAIT_LIMIT)) begin
            released  = 1'b1;
            eff_state = ret_q;
            state_d   = ret_q;
            if (!mem_ready) begin
               timeout_d = 1'b1;
            end
         end else begin
            stall_inc  = 1'b1;
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end

      mem_wait_req = mem_access && !mem_ready && !released;

      if (mem_wait_req && (eff_state != StMemWait) && (eff_state != StHalted)) begin
         ctrl       = CTRL_FREEZE;
         stall_inc  = 1'b1;
         ret_d      = eff_state;
         state_d    = StMemWait;
         wait_cnt_d = WAIT_CNT_W'(1);
      end else begin
         unique case (eff_state)
            StRun: begin
               if (branch_taken) begin
                  ctrl      = CTRL_FLUSH;
                  flush_inc = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d     = StFlush;
                     flush_rem_d = FLUSH_RELOAD;
                  end else begin
                     state_d = StRun;
                  end
               end else if (load_use_hazard) begin
                  ctrl      = CTRL_BUBBLE;
                  stall_inc = 1'b1;
               end else if (opcode_decode == HALT_OPCODE) begin
                  ctrl        = CTRL_BUBBLE;
                  state_d     = StDrain;
                  drain_cnt_d = '0;
               end else begin
                  ctrl = CTRL_GO;
               end
            end
            StFlush: begin
               ctrl = CTRL_FLUSH;
               if (flush_rem_q <= FLUSH_CNT_W'(1)) begin
                  state_d     = StRun;
                  flush_rem_d = '0;
               end else begin
                  flush_rem_d = flush_rem_q - 1'b1;
               end
            end
            StDrain: begin
               ctrl = CTRL_BUBBLE;
               if (drain_cnt_q >= DRAIN_LAST) begin
                  state_d = StHalted;
               end else begin
                  drain_cnt_d = drain_cnt_q + 1'b1;
               end
            end
            StHalted:  ctrl = CTRL_HALT;
            StMemWait: ctrl = CTRL_FREEZE;
            default:   state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         ret_q       <= StRun;
         flush_rem_q <= '0;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         flush_rem_q <= flush_rem_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign ctrl_out    = rst ? CTRL_RESET : ctrl;
   assign pc_en       = ctrl_out.pc_en;
   assign if_id_en    = ctrl_out.if_id_en;
   assign id_ex_en    = ctrl_out.id_ex_en;
   assign ex_mem_en   = ctrl_out.ex_mem_en;
   assign mem_wb_en   = ctrl_out.mem_wb_en;
   assign if_id_flush = ctrl_out.if_id_flush;
   assign id_ex_flush = ctrl_out.id_ex_flush;
   assign halted      = (state_q == StHalted);
   assign mem_timeout = timeout_q;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (stall_inc),
      .count(stall_count)
   );

   sat_counter #(
      .W(CNT_W)
   ) u_flush_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (flush_inc),
      .count(flush_count)
   );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed self-checking bench for pipeline_control_unit (narrow counters to reach saturation).
module tb_pipeline_control_unit;

   localparam int unsigned CW = 4;
   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   localparam logic [6:0] C_GO  = 7'b1111100;
   localparam logic [6:0] C_FRZ = 7'b0000000;
   localparam logic [6:0] C_BUB = 7'b0011101;
   localparam logic [6:0] C_FL  = 7'b1111111;
   localparam logic [6:0] C_HLT = 7'b0001100;
   localparam logic [6:0] C_RST = 7'b0000011;

   logic          clk = 1'b0;
   logic          rst, load_use_hazard, branch_taken, mem_access, mem_ready;
   logic [3:0]    opcode_decode;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, halted, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;
   logic [6:0]    ctl;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            exp_stall = 0;
   int            exp_flush = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

   pipeline_control_unit #(
      .FLUSH_CYCLES(2),
      .MEM_TIMEOUT (15),
      .DRAIN_CYCLES(3),
      .CNT_W       (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load_use_hazard(load_use_hazard),
      .branch_taken   (branch_taken),
      .mem_access     (mem_access),
      .mem_ready      (mem_ready),
      .opcode_decode  (opcode_decode),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .id_ex_en       (id_ex_en),
      .ex_mem_en      (ex_mem_en),
      .mem_wb_en      (mem_wb_en),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .halted         (halted),
      .mem_timeout    (mem_timeout),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   function automatic int sat(input int v);
      return (v > ((1 << CW) - 1)) ? ((1 << CW) - 1) : v;
   endfunction

   task automatic idle_inputs();
      load_use_hazard = 1'b0;
      branch_taken    = 1'b0;
      mem_access      = 1'b0;
      mem_ready       = 1'b0;
      opcode_decode   = 4'h0;
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      #3;
      n_cmp++;
      if (ctl !== C_RST) begin
         n_bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_RST);
      end
      n_cmp++;
      if (halted !== 1'b0 || mem_timeout !== 1'b0) begin
         n_bad++; $display("FAIL reset_flags got=%b%b want=00", halted, mem_timeout);
      end
      n_cmp++;
      if (stall_count !== '0 || flush_count !== '0) begin
         n_bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", stall_count, flush_count);
      end
      next_cycle();
      rst = 1'b0;
      #3;
      n_cmp++;
      if (ctl !== C_GO) begin
         n_bad++; $display("FAIL run_idle got=%b want=%b", ctl, C_GO);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      load_use_hazard = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_BUB || stall_count !== 4'd0) begin
         n_bad++; $display("FAIL lu_bubble got=%b/%0d want=%b/0", ctl, stall_count, C_BUB);
      end
      next_cycle();
      load_use_hazard = 1'b0;
      exp_stall = sat(exp_stall + 1);
      #3;
      n_cmp++;
      if (ctl !== C_GO || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL lu_resume got=%b/%0d want=%b/%0d", ctl, stall_count, C_GO, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_branch();
      branch_taken = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_FL) begin
         n_bad++; $display("FAIL br_cycle0 got=%b want=%b", ctl, C_FL);
      end
      next_cycle();
      branch_taken    = 1'b0;
      load_use_hazard = 1'b1;
      exp_flush++;
      #3;
      n_cmp++;
      if (ctl !== C_FL) begin
         n_bad++; $display("FAIL br_cycle1_lu_ignored got=%b want=%b", ctl, C_FL);
      end
      next_cycle();
      load_use_hazard = 1'b0;
      #3;
      n_cmp++;
      if (ctl !== C_GO || flush_count !== CW'(exp_flush) || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL br_done got=%b/%0d/%0d want=%b/%0d/%0d", ctl, flush_count, stall_count,
                  C_GO, exp_flush, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_branch_vs_load_use();
      branch_taken    = 1'b1;
      load_use_hazard = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_FL) begin
         n_bad++; $display("FAIL brlu_branch_wins got=%b want=%b", ctl, C_FL);
      end
      next_cycle();
      idle_inputs();
      exp_flush++;
      next_cycle();
      #3;
      n_cmp++;
      if (ctl !== C_GO || flush_count !== CW'(exp_flush) || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL brlu_counts got=%b/%0d/%0d want=%b/%0d/%0d", ctl, flush_count,
                  stall_count, C_GO, exp_flush, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_mem_wait();
      mem_access = 1'b1;
      mem_ready  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #3;
         n_cmp++;
         if (ctl !== C_FRZ) begin
            n_bad++; $display("FAIL mw_freeze[%0d] got=%b want=%b", i, ctl, C_FRZ);
         end
         next_cycle();
      end
      mem_ready = 1'b1;
      exp_stall = sat(exp_stall + 4);
      #3;
      n_cmp++;
      if (ctl !== C_GO || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL mw_release got=%b/%0d want=%b/%0d", ctl, stall_count, C_GO, exp_stall);
      end
      next_cycle();
      // Ready in the same cycle as the access: no stall at all.
      mem_access = 1'b1;
      mem_ready  = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_GO) begin
         n_bad++; $display("FAIL mw_same_cycle got=%b want=%b", ctl, C_GO);
      end
      next_cycle();
      idle_inputs();
      #3;
      n_cmp++;
      if (stall_count !== CW'(exp_stall)) begin
         n_bad++; $display("FAIL mw_same_cycle_cnt got=%0d want=%0d", stall_count, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_timeout();
      mem_access = 1'b1;
      mem_ready  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #3;
         n_cmp++;
         if (ctl !== C_FRZ || mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL to_freeze[%0d] got=%b/%b want=%b/0", i, ctl, mem_timeout, C_FRZ);
         end
         next_cycle();
      end
      #3;
      n_cmp++;
      if (ctl !== C_GO || mem_timeout !== 1'b0) begin
         n_bad++; $display("FAIL to_release got=%b/%b want=%b/0", ctl, mem_timeout, C_GO);
      end
      next_cycle();
      mem_access = 1'b0;
      exp_stall  = sat(exp_stall + 15);
      #3;
      n_cmp++;
      if (mem_timeout !== 1'b1 || ctl !== C_GO || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL to_sticky got=%b/%b/%0d want=1/%b/%0d", mem_timeout, ctl, stall_count,
                  C_GO, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_flush_mem_wait();
      branch_taken = 1'b1;
      next_cycle();
      branch_taken = 1'b0;
      mem_access   = 1'b1;
      mem_ready    = 1'b0;
      exp_flush++;
      #3;
      n_cmp++;
      if (ctl !== C_FRZ) begin
         n_bad++; $display("FAIL fmw_freeze got=%b want=%b", ctl, C_FRZ);
      end
      next_cycle();
      mem_ready = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_FL) begin
         n_bad++; $display("FAIL fmw_resume_flush got=%b want=%b", ctl, C_FL);
      end
      next_cycle();
      idle_inputs();
      exp_stall = sat(exp_stall + 1);
      #3;
      n_cmp++;
      if (ctl !== C_GO || flush_count !== CW'(exp_flush) || stall_count !== CW'(exp_stall)) begin
         n_bad++;
         $display("FAIL fmw_done got=%b/%0d/%0d want=%b/%0d/%0d", ctl, flush_count, stall_count,
                  C_GO, exp_flush, exp_stall);
      end
      next_cycle();
   endtask

   task automatic test_halt();
      opcode_decode = 4'hF;
      #3;
      n_cmp++;
      if (ctl !== C_BUB || halted !== 1'b0) begin
         n_bad++; $display("FAIL halt_accept got=%b/%b want=%b/0", ctl, halted, C_BUB);
      end
      next_cycle();
      opcode_decode = 4'h0;
      for (int i = 0; i < 3; i++) begin
         #3;
         n_cmp++;
         if (ctl !== C_BUB || halted !== 1'b0) begin
            n_bad++; $display("FAIL drain[%0d] got=%b/%b want=%b/0", i, ctl, halted, C_BUB);
         end
         next_cycle();
      end
      #3;
      n_cmp++;
      if (ctl !== C_HLT || halted !== 1'b1) begin
         n_bad++; $display("FAIL halted got=%b/%b want=%b/1", ctl, halted, C_HLT);
      end
      next_cycle();
      branch_taken    = 1'b1;
      load_use_hazard = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_HLT || halted !== 1'b1) begin
         n_bad++; $display("FAIL halted_hold got=%b/%b want=%b/1", ctl, halted, C_HLT);
      end
      next_cycle();
      idle_inputs();
      rst = 1'b1;
      #3;
      n_cmp++;
      if (ctl !== C_RST) begin
         n_bad++; $display("FAIL halt_rst_ctl got=%b want=%b", ctl, C_RST);
      end
      next_cycle();
      rst       = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      #3;
      n_cmp++;
      if (halted !== 1'b0 || mem_timeout !== 1'b0 || ctl !== C_GO ||
          stall_count !== '0 || flush_count !== '0) begin
         n_bad++;
         $display("FAIL halt_rst_state got=%b/%b/%b/%0d/%0d want=0/0/%b/0/0", halted,
                  mem_timeout, ctl, stall_count, flush_count, C_GO);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_flush_mem_wait();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
